// File: rtl/down_counter8_timer_if.sv
// Control and status bundle for the loadable down-counter / timer.
// The master drives requests and observes count and flags; the timer is the slave.
interface down_counter8_timer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output load, load_val, start, stop, en, auto_reload,
    input  count, busy, done, tc
  );

  modport slave (
    input  load, load_val, start, stop, en, auto_reload,
    output count, busy, done, tc
  );
endinterface

// File: rtl/down_counter8_timer.sv
// Loadable down-counter with one-shot and periodic timer modes.
// All outputs come straight from flops; the counter never wraps below zero.
module down_counter8_timer #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  down_counter8_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_nxt_s;
  logic             tc_r;
  logic             tc_nxt_s;
  logic             busy_r;
  logic             done_r;

  // Next-state logic: priority is load, then stop, then start, then counting.
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = count_r;
    reload_nxt_s = reload_r;
    tc_nxt_s     = 1'b0;

    if (bus.load) begin
      count_nxt_s  = bus.load_val;
      reload_nxt_s = bus.load_val;
      state_nxt_s  = IDLE;
    end else if (bus.stop) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && (count_r != ZERO_C)) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (!bus.en) begin
            state_nxt_s = RUN;
          end else if (count_r > ONE_C) begin
            count_nxt_s = count_r - ONE_C;
          end else if (count_r == ONE_C) begin
            tc_nxt_s = 1'b1;
            if (bus.auto_reload && (reload_r != ZERO_C)) begin
              count_nxt_s = reload_r;
            end else begin
              count_nxt_s = ZERO_C;
              state_nxt_s = DONE;
            end
          end else begin
            // A zero count while running is unreachable; retire safely without decrementing.
            state_nxt_s = DONE;
          end
        end
        DONE: begin
          if (bus.start && (reload_r != ZERO_C)) begin
            count_nxt_s = reload_r;
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, counter, reload value and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= ZERO_C;
      reload_r <= ZERO_C;
      tc_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      count_r  <= count_nxt_s;
      reload_r <= reload_nxt_s;
      tc_r     <= tc_nxt_s;
      busy_r   <= (state_nxt_s == RUN);
      done_r   <= (state_nxt_s == DONE);
    end
  end

  assign bus.count = count_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.tc    = tc_r;

endmodule

// File: tb/tb_down_counter8_timer.sv
// Self-checking bench: directed scenarios against fixed expectations plus
// randomized traffic against a behavioural timer model.
module tb_down_counter8_timer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  down_counter8_timer_if #(.WIDTH(8)) bus ();

  down_counter8_timer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int m_count;
  int m_reload;
  bit m_running;
  bit m_expired;
  bit m_tc;

  task automatic model_step();
    if (rst) begin
      m_count = 0; m_reload = 0; m_running = 0; m_expired = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (bus.load) begin
        m_count = bus.load_val; m_reload = bus.load_val;
        m_running = 0; m_expired = 0;
      end else if (bus.stop) begin
        m_running = 0; m_expired = 0;
      end else if (bus.start && !m_running && !m_expired && m_count != 0) begin
        m_running = 1;
      end else if (bus.start && m_expired && m_reload != 0) begin
        m_count = m_reload; m_expired = 0; m_running = 1;
      end else if (m_running && bus.en) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (bus.auto_reload && m_reload != 0) m_count = m_reload;
          else begin m_count = 0; m_running = 0; m_expired = 1; end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic ld, input logic [7:0] lv,
                      input logic st, input logic sp, input logic e, input logic ar);
    rst = r; bus.load = ld; bus.load_val = lv; bus.start = st;
    bus.stop = sp; bus.en = e; bus.auto_reload = ar;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done, bus.tc} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: count=%h busy=%b done=%b tc=%b, need 00 0 0 0",
               bus.count, bus.busy, bus.done, bus.tc);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_c;
    tick(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done} !== {8'h05, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL oneshot_start: count=%h busy=%b done=%b, need 05 1 0",
               bus.count, bus.busy, bus.done);
    end
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_c = (i >= 5) ? 8'h00 : 8'(5 - i);
      checks++;
      if ({bus.count, bus.tc, bus.done, bus.busy} !==
          {exp_c, (i == 5), (i >= 5), (i < 5)}) begin
        errors++;
        $display("FAIL oneshot_cyc%0d: count=%h tc=%b done=%b busy=%b, need %h %b %b %b",
                 i, bus.count, bus.tc, bus.done, bus.busy, exp_c, (i == 5), (i >= 5), (i < 5));
      end
    end
  endtask

  task automatic test_periodic();
    logic [7:0] seq [9];
    seq = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
    tick(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.count, bus.busy} !== {8'h03, 1'b1}) begin
      errors++;
      $display("FAIL periodic_start: count=%h busy=%b, need 03 1", bus.count, bus.busy);
    end
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({bus.count, bus.tc, bus.busy, bus.done} !== {seq[i], (i % 3 == 2), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL periodic_cyc%0d: count=%h tc=%b busy=%b done=%b, need %h %b 1 0",
                 i, bus.count, bus.tc, bus.busy, bus.done, seq[i], (i % 3 == 2));
      end
    end
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_enable_full_range();
    int enabled;
    int exp_c;
    logic e;
    enabled = 0;
    tick(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 530; i++) begin
      e = (i % 2 == 0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, e, 1'b0);
      if (e && enabled < 255) enabled++;
      exp_c = 255 - enabled;
      checks++;
      if ({bus.count, bus.tc, bus.done} !==
          {8'(exp_c), (e && enabled == 255 && bus.count == 8'h00 && i == 508), (enabled == 255)}) begin
        errors++;
        $display("FAIL range_cyc%0d: count=%h tc=%b done=%b, need %h tc_at_508 done=%b",
                 i, bus.count, bus.tc, bus.done, 8'(exp_c), (enabled == 255));
      end
    end
  endtask

  task automatic test_priority();
    tick(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.busy} !== {8'h07, 1'b1}) begin
      errors++;
      $display("FAIL prio_reach7: count=%h busy=%b, need 07 1", bus.count, bus.busy);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done} !== {8'h07, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_stop_start: count=%h busy=%b done=%b, need 07 0 0",
               bus.count, bus.busy, bus.done);
    end
    tick(1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.count, bus.busy} !== {8'h0A, 1'b0}) begin
      errors++;
      $display("FAIL prio_load_stop: count=%h busy=%b, need 0a 0", bus.count, bus.busy);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    // start while running must not restart the count
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.busy} !== {8'h07, 1'b1}) begin
      errors++;
      $display("FAIL prio_start_in_run: count=%h busy=%b, need 07 1", bus.count, bus.busy);
    end
    // stop on the terminal cycle wins over tc
    tick(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done, bus.tc} !== {8'h01, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_stop_terminal: count=%h busy=%b done=%b tc=%b, need 01 0 0 0",
               bus.count, bus.busy, bus.done, bus.tc);
    end
    // load of zero makes the following start a no-op
    tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done, bus.tc} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_zero_start: count=%h busy=%b done=%b tc=%b, need 00 0 0 0",
               bus.count, bus.busy, bus.done, bus.tc);
    end
  endtask

  task automatic test_restart_reset();
    tick(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.done, bus.busy} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_done: count=%h done=%b busy=%b, need 00 1 0",
               bus.count, bus.done, bus.busy);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done} !== {8'h04, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_reload: count=%h busy=%b done=%b, need 04 1 0",
               bus.count, bus.busy, bus.done);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done, bus.tc} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midrun: count=%h busy=%b done=%b tc=%b, need 00 0 0 0",
               bus.count, bus.busy, bus.done, bus.tc);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.count, bus.busy, bus.done, bus.tc} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL start_after_reset: count=%h busy=%b done=%b tc=%b, need 00 0 0 0",
               bus.count, bus.busy, bus.done, bus.tc);
    end
  endtask

  task automatic test_random();
    logic [7:0] lv;
    for (int i = 0; i < 2000; i++) begin
      lv = 8'($urandom_range(0, 12));
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0), lv,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.tc} !==
          {8'(m_count), m_running, m_expired, m_tc}) begin
        errors++;
        $display("FAIL random_cyc%0d: count=%h busy=%b done=%b tc=%b, need %h %b %b %b",
                 i, bus.count, bus.busy, bus.done, bus.tc,
                 8'(m_count), m_running, m_expired, m_tc);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.load_val = 8'h00; bus.start = 1'b0;
    bus.stop = 1'b0; bus.en = 1'b0; bus.auto_reload = 1'b0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_full_range();
    test_priority();
    test_restart_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter8_timer.md
Name: down_counter8_timer

Overview:
- Loadable 8-bit (parameterisable) down-counter and one-shot/periodic timer.
- Counts down from a loaded value to zero and signals terminal count.
- Instantiated beside the up-counter for timeout, delay and periodic-tick generation in level-0 designs.
- Fully synchronous, single clock domain, all outputs registered.

Parameters:
WIDTH, 8, counter and load-value width in bits

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
load  input  1  load request; samples load_val
load_val  input  WIDTH  value captured on load, into both count and reload register
start  input  1  single-cycle start/restart request
stop  input  1  single-cycle abort request
en  input  1  count enable; when low in RUN, count holds
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at terminal count
count  output  WIDTH  current counter value
busy  output  1  high while state is RUN
done  output  1  high while state is DONE (one-shot expired)
tc  output  1  one-cycle terminal-count pulse

Behaviour:
- Reset (rst=1 at a rising edge, overrides everything):
  - count=0, reload_reg=0, state=IDLE, busy=0, done=0, tc=0.
- Priority at each edge: rst > load > stop > start > en counting.
- State machine states: IDLE, RUN, DONE. busy=(state==RUN), done=(state==DONE), both registered with state.
- load, in any state:
  - count<=load_val, reload_reg<=load_val, state<=IDLE, tc<=0.
  - Load during RUN aborts the run.
- stop:
  - RUN -> IDLE, count holds its current value.
  - DONE -> IDLE, count stays 0.
  - No effect in IDLE.
- start in IDLE:
  - count!=0 -> RUN; count unchanged on the start edge.
  - count==0 -> ignored, stays IDLE, no tc.
- start in DONE:
  - reload_reg!=0 -> count<=reload_reg, state<=RUN.
  - Otherwise ignored.
- start in RUN is ignored; it does not restart.
- Latency:
  - busy rises at the edge that samples start.
  - First decrement at the next edge with en=1.
  - N cycles of en=1 after start take count from N to terminal.
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1 (terminal), tc<=1 for exactly one cycle:
  - auto_reload=1 and reload_reg!=0: count<=reload_reg, stay RUN. Period = reload_reg enabled cycles; count never shows 0.
  - Otherwise: count<=0, state<=DONE.
- RUN, en=0: count and state hold; tc=0.
- tc is 0 in every cycle not listed above.
- count never wraps: no decrement ever occurs at 0. Underflow 0->max is illegal and must not occur.
- load_val=0 followed by start: the start is ignored.
- stop on the terminal cycle (count==1, en=1): stop wins. State goes to IDLE with count=1 held, and no tc.
- rst asserted mid-run: all outputs take reset values at that edge. The block stays IDLE until a new load and start.

Test Plan:
1. Reset check:
   - Stimulus: rst=1 for 2 cycles, then check.
   - Required: count=00, busy=0, done=0, tc=0.
2. One-shot:
   - Stimulus: load 05, start, en=1.
   - Required: count 05,04,03,02,01,00. tc=1 only in the cycle count becomes 00. done=1 and busy=0 from that edge. count holds 00 for 10 further cycles.
3. Periodic:
   - Stimulus: load 03, auto_reload=1, start, en=1 for 9 cycles.
   - Required: count 03,02,01,03,02,01,03,02,01,03. tc pulses every 3rd cycle (3 pulses). busy stays 1.
4. Enable gating and full range:
   - Stimulus: load FF, start, en toggled 1/0.
   - Required: count decrements only on en=1 cycles. Reaches 00 after exactly 255 enabled cycles with no wrap.
5. Priority/abort:
   - Stimulus: mid-run at count 07, assert stop and start together.
   - Required: IDLE with count 07.
   - Stimulus: then load 0A with stop together.
   - Required: count 0A, IDLE.
   - Stimulus: then start.
   - Required: RUN from 0A.
6. Restart and reset mid-run:
   - Stimulus: in DONE, start.
   - Required: count reloads the last load value, RUN.
   - Stimulus: then rst during RUN.
   - Required: all outputs 0 next edge. A following start without load is ignored.
